// File: rtl/i2c_init_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_init_sequencer
//  Purpose  : Walks an external table of NUM_REGS 16-bit register words and
//             issues each as a 24-bit {DEV_ADDR, word} write through the
//             i2c_controller start/done handshake. NACKs are retried a bounded
//             number of times, hung transfers time out, transfers are spaced
//             by an idle gap, and the sequence can be re-triggered.
//  Ports    : clk        - system clock
//             reset_n    - asynchronous active-low reset
//             start_cfg  - 1-cycle pulse, (re)run from index 0 when not busy
//             tbl_index  - current table index (to combinational table)
//             tbl_data   - table word at tbl_index, same cycle
//             i2c_data   - 24-bit write word to the controller
//             i2c_start  - 1-cycle start pulse to the controller
//             i2c_done   - controller idle/done level
//             i2c_ack    - all bytes ACKed, valid with i2c_done
//             busy       - sequence in progress
//             cfg_done   - sticky, every entry written successfully
//             cfg_error  - sticky, an entry exhausted its retries
//             err_index  - failing entry index while cfg_error is set
//  Revision : 1.0  initial release
// ============================================================================
module i2c_init_sequencer #(
   parameter logic [7:0] DEV_ADDR    = 8'h34,
   parameter int         NUM_REGS    = 11,
   parameter int         IDX_W       = 4,
   parameter int         MAX_RETRY   = 3,
   parameter int         GAP_CYCLES  = 16,
   parameter int         TIMEOUT_CYC = 65535,
   parameter bit         AUTO_START  = 1'b1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start_cfg,
   output logic [IDX_W-1:0] tbl_index,
   input  logic [15:0]      tbl_data,
   output logic [23:0]      i2c_data,
   output logic             i2c_start,
   input  logic             i2c_done,
   input  logic             i2c_ack,
   output logic             busy,
   output logic             cfg_done,
   output logic             cfg_error,
   output logic [IDX_W-1:0] err_index
);

   // Counter widths; each counter needs at least one bit even when its
   // parameter collapses the feature (no retries, no gap).
   localparam int c_RTRY_W = (MAX_RETRY   > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam int c_GAP_W  = (GAP_CYCLES  > 1) ? $clog2(GAP_CYCLES)    : 1;
   localparam int c_TMO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC)   : 1;

   localparam logic [IDX_W-1:0]    c_LAST_IDX  = IDX_W'(NUM_REGS - 1);
   localparam logic [c_RTRY_W-1:0] c_RETRY_MAX = c_RTRY_W'(MAX_RETRY);
   localparam logic [c_GAP_W-1:0]  c_GAP_LAST  = c_GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [c_TMO_W-1:0]  c_TMO_LAST  = c_TMO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_PULSE = 3'd2,
      S_WAIT  = 3'd3,
      S_GAP   = 3'd4,
      S_DONE  = 3'd5,
      S_ERROR = 3'd6
   } state_t;

   // With no gap configured the retry/advance path skips GAP entirely.
   localparam state_t c_AFTER_XFER = (GAP_CYCLES == 0) ? S_LOAD : S_GAP;

   state_t              r_state;
   logic                r_seen_busy;
   logic [c_RTRY_W-1:0] r_retry;
   logic [c_GAP_W-1:0]  r_gap;
   logic [c_TMO_W-1:0]  r_tmo;
   logic                w_complete;

   // A done level that is still high from the previous transfer must not be
   // taken as completion: the controller has to be seen busy first.
   assign w_complete = i2c_done && r_seen_busy;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         tbl_index   <= '0;
         i2c_data    <= '0;
         i2c_start   <= 1'b0;
         busy        <= 1'b0;
         cfg_done    <= 1'b0;
         cfg_error   <= 1'b0;
         err_index   <= '0;
         r_seen_busy <= 1'b0;
         r_retry     <= '0;
         r_gap       <= '0;
         r_tmo       <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (AUTO_START || start_cfg) begin
                  tbl_index <= '0;
                  r_retry   <= '0;
                  busy      <= 1'b1;
                  r_state   <= S_LOAD;
               end
            end

            S_LOAD: begin
               i2c_data  <= {DEV_ADDR, tbl_data};
               i2c_start <= 1'b1;
               r_state   <= S_PULSE;
            end

            S_PULSE: begin
               i2c_start   <= 1'b0;
               r_seen_busy <= 1'b0;
               r_tmo       <= '0;
               r_state     <= S_WAIT;
            end

            S_WAIT: begin
               if (!i2c_done) begin
                  r_seen_busy <= 1'b1;
               end
               if (w_complete && i2c_ack) begin
                  r_retry <= '0;
                  if (tbl_index == c_LAST_IDX) begin
                     busy     <= 1'b0;
                     cfg_done <= 1'b1;
                     r_state  <= S_DONE;
                  end else begin
                     tbl_index <= tbl_index + IDX_W'(1);
                     r_gap     <= '0;
                     r_state   <= c_AFTER_XFER;
                  end
               end else if (w_complete || (r_tmo == c_TMO_LAST)) begin
                  // NACK and timeout share the same retry budget.
                  if (r_retry == c_RETRY_MAX) begin
                     busy      <= 1'b0;
                     cfg_error <= 1'b1;
                     err_index <= tbl_index;
                     r_state   <= S_ERROR;
                  end else begin
                     r_retry <= r_retry + c_RTRY_W'(1);
                     r_gap   <= '0;
                     r_state <= c_AFTER_XFER;
                  end
               end else begin
                  r_tmo <= r_tmo + c_TMO_W'(1);
               end
            end

            S_GAP: begin
               if (r_gap == c_GAP_LAST) begin
                  r_state <= S_LOAD;
               end else begin
                  r_gap <= r_gap + c_GAP_W'(1);
               end
            end

            S_DONE, S_ERROR: begin
               if (start_cfg) begin
                  cfg_done  <= 1'b0;
                  cfg_error <= 1'b0;
                  err_index <= '0;
                  r_retry   <= '0;
                  tbl_index <= '0;
                  busy      <= 1'b1;
                  r_state   <= S_LOAD;
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_i2c_init_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_init_sequencer
//  Purpose  : Self-checking bench for i2c_init_sequencer. Two instances:
//             u_dut0 (GAP 16, auto start) and u_dut1 (GAP 0, manual start),
//             each driven by a small behavioural i2c_controller model.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_i2c_init_sequencer;

   localparam int LAT = 4;    // controller busy cycles per transfer

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n   [2];
   logic        start_cfg [2];
   logic [3:0]  tbl_index [2];
   logic [15:0] tbl_data  [2];
   logic [23:0] i2c_data  [2];
   logic        i2c_start [2];
   logic        i2c_done  [2];
   logic        i2c_ack   [2];
   logic        busy      [2];
   logic        cfg_done  [2];
   logic        cfg_error [2];
   logic [3:0]  err_index [2];

   logic [15:0] rom [11] = '{16'h0c10, 16'h0017, 16'h0217, 16'h0479, 16'h0679, 16'h0812,
                             16'h0a06, 16'h0e01, 16'h1000, 16'h0c00, 16'h1201};

   function automatic logic [15:0] rom_at(input logic [3:0] i);
      return (i < 4'd11) ? rom[i] : 16'hdead;
   endfunction

   assign tbl_data[0] = rom_at(tbl_index[0]);
   assign tbl_data[1] = rom_at(tbl_index[1]);

   i2c_init_sequencer #(.TIMEOUT_CYC(100)) u_dut0 (
      .clk(clk), .reset_n(reset_n[0]), .start_cfg(start_cfg[0]),
      .tbl_index(tbl_index[0]), .tbl_data(tbl_data[0]), .i2c_data(i2c_data[0]),
      .i2c_start(i2c_start[0]), .i2c_done(i2c_done[0]), .i2c_ack(i2c_ack[0]),
      .busy(busy[0]), .cfg_done(cfg_done[0]), .cfg_error(cfg_error[0]),
      .err_index(err_index[0]));

   i2c_init_sequencer #(.GAP_CYCLES(0), .AUTO_START(1'b0), .TIMEOUT_CYC(100)) u_dut1 (
      .clk(clk), .reset_n(reset_n[1]), .start_cfg(start_cfg[1]),
      .tbl_index(tbl_index[1]), .tbl_data(tbl_data[1]), .i2c_data(i2c_data[1]),
      .i2c_start(i2c_start[1]), .i2c_done(i2c_done[1]), .i2c_ack(i2c_ack[1]),
      .busy(busy[1]), .cfg_done(cfg_done[1]), .cfg_error(cfg_error[1]),
      .err_index(err_index[1]));

   // Controller model configuration, written only by the stimulus process.
   int nack_idx [2];   // entry to NACK
   int nack_cnt [2];   // number of NACKs given to that entry per run
   bit hang     [2];   // never complete
   int stale    [2];   // cycles done stays high after start

   // Model state and start log, written only by the model process.
   typedef struct {
      int          inst;
      logic [23:0] data;
      int          cyc;
   } ev_t;
   ev_t log_q[$];
   int  cyc = 0;
   int  cnt      [2];
   int  nfail    [2];
   bit  pend_ack [2];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int k = 0; k < 2; k++) begin
         if (!reset_n[k]) begin
            i2c_done[k] <= 1'b1;
            i2c_ack[k]  <= 1'b0;
            cnt[k]      <= 0;
            nfail[k]    <= 0;
            pend_ack[k] <= 1'b0;
         end else if (i2c_start[k]) begin
            log_q.push_back('{k, i2c_data[k], cyc});
            i2c_ack[k] <= 1'b0;
            if (stale[k] == 0 || hang[k]) i2c_done[k] <= 1'b0;
            cnt[k] <= hang[k] ? 0 : stale[k] + LAT;
            if (int'(tbl_index[k]) == nack_idx[k] && nfail[k] < nack_cnt[k]) begin
               pend_ack[k] <= 1'b0;
               nfail[k]    <= nfail[k] + 1;
            end else begin
               pend_ack[k] <= 1'b1;
               if (int'(tbl_index[k]) != nack_idx[k]) nfail[k] <= 0;
            end
         end else if (cnt[k] > 0) begin
            cnt[k] <= cnt[k] - 1;
            if (cnt[k] == LAT + 1) i2c_done[k] <= 1'b0;
            if (cnt[k] == 1) begin
               i2c_done[k] <= 1'b1;
               i2c_ack[k]  <= pend_ack[k];
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   int checks = 0;
   int fails  = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   typedef struct {
      int         inst;
      bit         pulse;      // 1 = start_cfg, 0 = reset release (auto start)
      bit         mid_pulse;  // extra start_cfg while busy
      int         nidx;
      int         ncnt;
      bit         hang;
      int         stale;
      bit         e_done;
      bit         e_err;
      logic [3:0] e_eidx;
      logic [3:0] e_idx;
      int         e_space;    // cycles between first two starts
   } vec_t;

   logic [23:0] exp_q[$];
   int          rd = 0;

   // Reference sequencing: which words should go out, in order.
   task automatic build_exp(input vec_t v);
      int i  = 0;
      int r  = 0;
      int nf = 0;
      bit fail;
      exp_q.delete();
      forever begin
         exp_q.push_back({8'h34, rom[i]});
         fail = v.hang || (i == v.nidx && nf < v.ncnt);
         if (fail) begin
            nf++;
            if (r == 3) break;
            r++;
         end else begin
            r = 0;
            if (i == 10) break;
            i++;
         end
      end
   endtask

   task automatic pulse_start(input int k);
      @(negedge clk) start_cfg[k] = 1'b1;
      @(negedge clk) start_cfg[k] = 1'b0;
   endtask

   task automatic wait_end(input int k, input string tag);
      int n = 0;
      while (!(busy[k] == 1'b0 && (cfg_done[k] || cfg_error[k])) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_end_timeout"}, 64'(n >= 3000), 64'd0);
   endtask

   task automatic compare_log(input int k, input string tag, input int space);
      ev_t got[$];
      int  n;
      for (int j = rd; j < log_q.size(); j++)
         if (log_q[j].inst == k) got.push_back(log_q[j]);
      chk({tag, "_write_count"}, 64'(got.size()), 64'(exp_q.size()));
      n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
      for (int j = 0; j < n; j++)
         chk($sformatf("%s_write%0d", tag, j), 64'(got[j].data), 64'(exp_q[j]));
      if (space > 0 && got.size() >= 2)
         chk({tag, "_spacing"}, 64'(got[1].cyc - got[0].cyc), 64'(space));
   endtask

   vec_t vecs [5];

   initial begin
      vecs[0] = '{0, 1'b0, 1'b1,  99,    0, 1'b0, 0, 1'b1, 1'b0, 4'd0, 4'd10,  23};
      vecs[1] = '{0, 1'b1, 1'b0,   3,    2, 1'b0, 0, 1'b1, 1'b0, 4'd0, 4'd10,  23};
      vecs[2] = '{0, 1'b1, 1'b0,   5, 1000, 1'b0, 0, 1'b0, 1'b1, 4'd5, 4'd5,   23};
      vecs[3] = '{0, 1'b1, 1'b0,  99,    0, 1'b1, 0, 1'b0, 1'b1, 4'd0, 4'd0,  118};
      vecs[4] = '{1, 1'b1, 1'b0,  99,    0, 1'b0, 2, 1'b1, 1'b0, 4'd0, 4'd10,   9};

      for (int k = 0; k < 2; k++) begin
         reset_n[k]   = 1'b0;
         start_cfg[k] = 1'b0;
         nack_idx[k]  = 99;
         nack_cnt[k]  = 0;
         hang[k]      = 1'b0;
         stale[k]     = 0;
      end

      // Reset values while reset is held.
      #12;
      for (int k = 0; k < 2; k++)
         chk($sformatf("reset_state%0d", k),
             64'({tbl_index[k], i2c_data[k], i2c_start[k], busy[k], cfg_done[k],
                  cfg_error[k], err_index[k]}), 64'd0);

      // Manual-start instance must stay idle after reset release.
      @(negedge clk) reset_n[1] = 1'b1;
      repeat (20) @(negedge clk);
      chk("manual_idle_busy", 64'(busy[1]), 64'd0);
      chk("manual_idle_writes", 64'(log_q.size()), 64'd0);

      for (int s = 0; s < 5; s++) begin
         automatic vec_t  v   = vecs[s];
         automatic int    k   = v.inst;
         automatic string tag = $sformatf("vec%0d", s);
         nack_idx[k] = v.nidx;
         nack_cnt[k] = v.ncnt;
         hang[k]     = v.hang;
         stale[k]    = v.stale;
         build_exp(v);
         rd = log_q.size();
         if (v.pulse) begin
            pulse_start(k);
            chk({tag, "_restart_flags"},
                64'({busy[k], cfg_done[k], cfg_error[k], err_index[k]}), 64'b1_0_0_0000);
         end else begin
            @(negedge clk) reset_n[k] = 1'b1;
         end
         if (v.mid_pulse) begin
            repeat (60) @(negedge clk);
            pulse_start(k);
         end
         wait_end(k, tag);
         compare_log(k, tag, v.e_space);
         chk({tag, "_flags"}, 64'({cfg_done[k], cfg_error[k], busy[k], i2c_start[k]}),
             64'({v.e_done, v.e_err, 1'b0, 1'b0}));
         chk({tag, "_tbl_index"}, 64'(tbl_index[k]), 64'(v.e_idx));
         chk({tag, "_err_index"}, 64'(err_index[k]), 64'(v.e_eidx));
      end

      // Asynchronous reset in the middle of a transfer, then auto restart.
      begin
         automatic int     n = 0;
         automatic vec_t   v = vecs[0];
         hang[0] = 1'b0;
         pulse_start(0);
         while (!i2c_start[0] && n < 50) begin
            @(negedge clk);
            n++;
         end
         chk("midwait_start_seen", 64'(i2c_start[0]), 64'd1);
         repeat (2) @(negedge clk);
         #2 reset_n[0] = 1'b0;
         #1;
         chk("midwait_async_reset",
             64'({tbl_index[0], i2c_data[0], i2c_start[0], busy[0], cfg_done[0],
                  cfg_error[0], err_index[0]}), 64'd0);
         @(negedge clk);
         chk("midwait_reset_held", 64'({busy[0], i2c_data[0]}), 64'd0);
         build_exp(v);
         rd = log_q.size();
         reset_n[0] = 1'b1;
         wait_end(0, "after_reset");
         compare_log(0, "after_reset", 0);
         chk("after_reset_done", 64'({cfg_done[0], cfg_error[0]}), 64'b10);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
